// File: rtl/dds_signal_generator.sv
// dds_signal_generator: phase-accumulator sine source for FIR stimulus.
// Optional second summed tone: define DDS_SECOND_TONE_EN.
module dds_signal_generator #(
  parameter int PHASE_W = 16,
  parameter int N_PROBE = 8,
  parameter logic [PHASE_W-1:0] FCW0_INIT = 16'h0400,
  parameter logic [PHASE_W-1:0] FCW1_INIT = 16'h3000
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic [PHASE_W-1:0] i_fcw0,
  input  logic [PHASE_W-1:0] i_fcw1,
  input  logic               i_load,
  output logic               o_load_ack,
  output logic [N_PROBE-1:0] o_signal,
  output logic               o_valid
);

  // quarter-wave table: round(127*sin(2*pi*k/256)), k = 0..64
  localparam int QTAB [65] = '{
    0,   3,   6,   9,   12,  16,  19,  22,
    25,  28,  31,  34,  37,  40,  43,  46,
    49,  51,  54,  57,  60,  63,  65,  68,
    71,  73,  76,  78,  81,  83,  85,  88,
    90,  92,  94,  96,  98,  100, 102, 104,
    106, 107, 109, 111, 112, 113, 115, 116,
    117, 118, 120, 121, 122, 122, 123, 124,
    125, 125, 126, 126, 126, 127, 127, 127,
    127
  };

  function automatic logic [7:0] sine(input logic [7:0] p);
    logic [6:0] k;
    logic [7:0] mag;
    k = p[6] ? 7'd64 - {1'b0, p[5:0]} : {1'b0, p[5:0]};
    mag = {1'b0, 7'(QTAB[k])};
    sine = p[7] ? -mag : mag;
  endfunction

  logic [PHASE_W-1:0] ph0;
  logic [PHASE_W-1:0] fcw0;
  logic [PHASE_W-1:0] sh0;
  logic [PHASE_W:0]   sum0;
  logic               carry0;
  logic               pend;
  logic               apply;
  logic               v1;
  logic [7:0]         s0;
  logic [7:0]         out;

  assign sum0   = {1'b0, ph0} + {1'b0, fcw0};
  assign carry0 = sum0[PHASE_W];
  // retune only on a wrap (or when stopped) so the wave never jumps
  assign apply  = pend & i_en & (carry0 | (fcw0 == '0));

  // tone-0 accumulator plus the shadow/active word handshake
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      ph0        <= '0;
      fcw0       <= FCW0_INIT;
      sh0        <= '0;
      pend       <= 1'b0;
      o_load_ack <= 1'b0;
    end else begin
      if (i_en)
        ph0 <= sum0[PHASE_W-1:0];
      if (i_load)
        sh0 <= i_fcw0;
      if (apply)
        fcw0 <= i_load ? i_fcw0 : sh0;
      pend       <= ~apply & (pend | i_load);
      o_load_ack <= apply;
    end
  end

`ifdef DDS_SECOND_TONE_EN
  logic [PHASE_W-1:0] ph1;
  logic [PHASE_W-1:0] fcw1;
  logic [PHASE_W-1:0] sh1;
  logic [7:0]         s1;
  logic [8:0]         sum9;

  // tone-1 accumulator and lookup, retuned together with tone 0
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      ph1  <= '0;
      fcw1 <= FCW1_INIT;
      sh1  <= '0;
      s1   <= '0;
    end else begin
      if (i_en)
        ph1 <= ph1 + fcw1;
      if (i_load)
        sh1 <= i_fcw1;
      if (apply)
        fcw1 <= i_load ? i_fcw1 : sh1;
      s1 <= sine(ph1[PHASE_W-1 -: 8]);
    end
  end

  assign sum9 = {s0[7], s0} + {s1[7], s1};
  assign out  = sum9[8:1];
`else
  logic unused_tone1;
  assign unused_tone1 = ^{i_fcw1, FCW1_INIT};
  assign out = s0;
`endif

  // two-stage output pipeline: lookup, then hold-or-update sample
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      s0       <= '0;
      v1       <= 1'b0;
      o_signal <= '0;
      o_valid  <= 1'b0;
    end else begin
      s0      <= sine(ph0[PHASE_W-1 -: 8]);
      v1      <= i_en;
      o_valid <= v1;
      if (v1)
        o_signal <= out;
    end
  end

endmodule

// File: tb/tb_dds_signal_generator.sv
// tb_dds_signal_generator: directed vectors for dds_signal_generator.
// Expected samples halve when DDS_SECOND_TONE_EN is defined (tone 1 at 0).
module tb_dds_signal_generator;

  logic        clock;
  logic        i_reset;
  logic        i_en;
  logic [15:0] i_fcw0;
  logic [15:0] i_fcw1;
  logic        i_load;
  logic        o_load_ack;
  logic [7:0]  o_signal;
  logic        o_valid;

  int n_chk;
  int n_fail;
  int ncyc;
  int nack;

  typedef struct {
    logic        en;
    logic        ld;
    logic [15:0] fcw;
    logic        val;
    logic [7:0]  sig;
    logic        ack;
  } vec_t;

  vec_t tbl [28];

  dds_signal_generator dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_en       (i_en),
    .i_fcw0     (i_fcw0),
    .i_fcw1     (i_fcw1),
    .i_load     (i_load),
    .o_load_ack (o_load_ack),
    .o_signal   (o_signal),
    .o_valid    (o_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t v(
    input logic en, input logic ld, input logic [15:0] f,
    input logic val, input logic [7:0] s, input logic ack);
    vec_t r;
    r.en = en; r.ld = ld; r.fcw = f;
    r.val = val; r.sig = s; r.ack = ack;
    return r;
  endfunction

  function automatic logic [7:0] exp_sig(input logic [7:0] s);
`ifdef DDS_SECOND_TONE_EN
    return {s[7], s[7:1]};
`else
    return s;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    ncyc++;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; ncyc = 0; nack = 0;
    i_reset = 1'b0; i_en = 1'b0; i_load = 1'b0;
    i_fcw0 = '0; i_fcw1 = '0;

    tbl[0]  = v(1, 1, 16'h8000, 1, 8'h00, 0);
    tbl[1]  = v(1, 0, 16'h0000, 1, 8'h7F, 0);
    tbl[2]  = v(1, 0, 16'h0000, 1, 8'h00, 1);
    tbl[3]  = v(1, 0, 16'h0000, 1, 8'h81, 0);
    tbl[4]  = v(1, 0, 16'h0000, 1, 8'h00, 0);
    tbl[5]  = v(1, 0, 16'h0000, 1, 8'h00, 0);
    tbl[6]  = v(1, 0, 16'h0000, 1, 8'h00, 0);
    tbl[7]  = v(1, 1, 16'h0000, 1, 8'h00, 0);
    tbl[8]  = v(1, 0, 16'h0000, 1, 8'h00, 1);
    tbl[9]  = v(1, 0, 16'h0000, 1, 8'h00, 0);
    tbl[10] = v(1, 1, 16'h1000, 1, 8'h00, 0);
    tbl[11] = v(1, 1, 16'h2000, 1, 8'h00, 1);
    tbl[12] = v(1, 0, 16'h0000, 1, 8'h00, 0);
    tbl[13] = v(1, 0, 16'h0000, 1, 8'h00, 0);
    tbl[14] = v(1, 0, 16'h0000, 1, 8'h5A, 0);
    tbl[15] = v(1, 0, 16'h0000, 1, 8'h7F, 0);
    tbl[16] = v(1, 0, 16'h0000, 1, 8'h5A, 0);
    tbl[17] = v(0, 0, 16'h0000, 1, 8'h00, 0);
    tbl[18] = v(0, 0, 16'h0000, 0, 8'h00, 0);
    tbl[19] = v(0, 0, 16'h0000, 0, 8'h00, 0);
    tbl[20] = v(0, 0, 16'h0000, 0, 8'h00, 0);
    tbl[21] = v(0, 0, 16'h0000, 0, 8'h00, 0);
    tbl[22] = v(1, 0, 16'h0000, 0, 8'h00, 0);
    tbl[23] = v(1, 0, 16'h0000, 1, 8'hA6, 0);
    tbl[24] = v(1, 0, 16'h0000, 1, 8'h81, 0);
    tbl[25] = v(1, 0, 16'h0000, 1, 8'hA6, 0);
    tbl[26] = v(1, 0, 16'h0000, 1, 8'h00, 0);
    tbl[27] = v(1, 1, 16'h1000, 1, 8'h5A, 0);

    #1;
    chk("reset o_signal", o_signal, 0);
    chk("reset o_valid", o_valid, 0);
    chk("reset o_load_ack", o_load_ack, 0);

    repeat (3) @(posedge clock);
    #1;
    i_reset = 1'b1;
    i_en = 1'b1;
    ncyc = 0;

    for (int k = 0; k < 10 && !o_valid; k++) step();
    chk("first valid latency", ncyc, 2);
    chk("first sample", o_signal, 0);

    i_load = 1'b1; i_fcw0 = 16'h4000; i_fcw1 = 16'h0000;
    step();
    i_load = 1'b0;
    for (int k = 0; k < 100 && !o_load_ack; k++) step();
    chk("load ack seen", o_load_ack, 1);
    chk("load ack on wrap cycle", ncyc, 64);
    step();

    for (int r = 0; r < 28; r++) begin
      i_en = tbl[r].en;
      i_load = tbl[r].ld;
      i_fcw0 = tbl[r].fcw;
      i_fcw1 = 16'h0000;
      step();
      chk($sformatf("row%0d o_valid", r), o_valid, tbl[r].val);
      chk($sformatf("row%0d o_signal", r), o_signal, exp_sig(tbl[r].sig));
      chk($sformatf("row%0d o_load_ack", r), o_load_ack, tbl[r].ack);
    end
    i_load = 1'b0;

    #2;
    i_reset = 1'b0;
    #1;
    chk("async reset o_signal", o_signal, 0);
    chk("async reset o_valid", o_valid, 0);
    chk("async reset o_load_ack", o_load_ack, 0);

    @(posedge clock);
    #1;
    i_reset = 1'b1;
    i_en = 1'b1;
    step();
    step();
    chk("post-reset valid", o_valid, 1);
    chk("post-reset sample", o_signal, 0);
    for (int k = 0; k < 78; k++) begin
      step();
      if (o_load_ack) nack++;
    end
    chk("discarded load acks", nack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
